// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the execute-side branch resolution queue: entry layout and packing helper.
package branch_resolve_pkg;

    // Entry layout: {is_jal, taken, pc[31:0], target[31:0]}
    localparam int ENT_TGT   = 0;
    localparam int ENT_PC    = 32;
    localparam int ENT_TAKEN = 64;
    localparam int ENT_JAL   = 65;
    localparam int ENTRY_W   = 66;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic        is_jal,
                                                      input logic        taken,
                                                      input logic [31:0] pc,
                                                      input logic [31:0] target);
        pack_entry = {is_jal, taken, pc, target};
    endfunction

endpackage

// File: rtl/branch_resolve_fifo.sv
// In-order prediction queue: DEPTH x WIDTH storage with push/pop, synchronous clear and occupancy count.
module bp_pred_fifo
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (PW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[head];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[tail] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (clr) begin
            tail <= head;
            cnt  <= '0;
        end else begin
            if (do_push)
                tail <= tail + PW'(1);
            if (do_pop)
                head <= head + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Execute-side branch resolution: queues fetch predictions, checks the oldest against the actual
// outcome, and produces a registered redirect pulse plus the predictor training pair.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid,
    output logic                     pred_ready,
    input  logic                     pred_is_jal,
    input  logic                     pred_taken,
    input  logic [31:0]              pred_pc,
    input  logic [31:0]              pred_target,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic [31:0]              res_target,
    input  logic                     flush_in,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc,
    output logic                     train_valid,
    output logic                     train_taken,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow_err,
    output logic [CNT_W-1:0]         branch_cnt,
    output logic [CNT_W-1:0]         mispred_cnt
);
    logic [ENTRY_W-1:0] head_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push;
    logic               clr;
    logic               mispredict;
    logic               head_jal;
    logic               head_taken;
    logic [31:0]        head_pc;
    logic [31:0]        head_tgt;
    logic [31:0]        restart_pc;

    logic               redirect_vld_p1;
    logic [31:0]        redirect_pc_p1;
    logic               train_vld_p1;
    logic               train_taken_p1;
    logic               underflow_q;
    logic [CNT_W-1:0]   branch_cnt_q;
    logic [CNT_W-1:0]   mispred_cnt_q;

    assign head_jal   = head_entry[ENT_JAL];
    assign head_taken = head_entry[ENT_TAKEN];
    assign head_pc    = head_entry[ENT_PC +: 32];
    assign head_tgt   = head_entry[ENT_TGT +: 32];

    assign pred_ready = !fifo_full;
    assign pop        = res_valid && !fifo_empty;
    assign mispredict = pop && ((res_taken != head_taken) ||
                                (res_taken && (res_target != head_tgt)));
    assign restart_pc = res_taken ? res_target : head_pc + 32'd4;

    // A mispredict or external flush empties the queue; any same-cycle push is wrong-path.
    assign clr  = mispredict || flush_in;
    assign push = pred_valid && pred_ready && !clr;

    bp_pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata (pack_entry(pred_is_jal, pred_taken, pred_pc, pred_target)),
        .rdata (head_entry),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // p0 -> p1: resolution result registered toward fetch and the predictor
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_vld_p1 <= 1'b0;
            redirect_pc_p1  <= '0;
            train_vld_p1    <= 1'b0;
            train_taken_p1  <= 1'b0;
            underflow_q     <= 1'b0;
            branch_cnt_q    <= '0;
            mispred_cnt_q   <= '0;
        end else begin
            redirect_vld_p1 <= mispredict;
            if (mispredict)
                redirect_pc_p1 <= restart_pc;
            train_vld_p1   <= pop && !head_jal;
            train_taken_p1 <= pop && res_taken;
            if (res_valid && fifo_empty)
                underflow_q <= 1'b1;
            if (pop && !head_jal)
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if (mispredict)
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end

    assign redirect_valid = redirect_vld_p1;
    assign redirect_pc    = redirect_pc_p1;
    assign train_valid    = train_vld_p1;
    assign train_taken    = train_taken_p1;
    assign underflow_err  = underflow_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: hand-computed expectations for push, resolve, flush and reset cases.
module tb_branch_resolve;
    import branch_resolve_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid, pred_ready, pred_is_jal, pred_taken;
    logic [31:0] pred_pc, pred_target;
    logic        res_valid, res_taken;
    logic [31:0] res_target;
    logic        flush_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        train_valid, train_taken;
    logic [2:0]  count;
    logic        underflow_err;
    logic [31:0] branch_cnt, mispred_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    branch_resolve #(.DEPTH(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_is_jal(pred_is_jal),
        .pred_taken(pred_taken), .pred_pc(pred_pc), .pred_target(pred_target),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .flush_in(flush_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .train_valid(train_valid), .train_taken(train_taken),
        .count(count), .underflow_err(underflow_err),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pred(input logic jal, input logic tk, input logic [31:0] pc, input logic [31:0] tgt);
        pred_valid  = 1'b1;
        pred_is_jal = jal;
        pred_taken  = tk;
        pred_pc     = pc;
        pred_target = tgt;
    endtask

    task automatic set_res(input logic tk, input logic [31:0] tgt);
        res_valid  = 1'b1;
        res_taken  = tk;
        res_target = tgt;
    endtask

    task automatic idle();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        flush_in   = 1'b0;
    endtask

    task automatic push(input logic jal, input logic tk, input logic [31:0] pc, input logic [31:0] tgt);
        set_pred(jal, tk, pc, tgt);
        step();
        idle();
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tgt);
        set_res(tk, tgt);
        step();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        pred_is_jal = 1'b0; pred_taken = 1'b0; pred_pc = '0; pred_target = '0;
        res_taken = 1'b0; res_target = '0;
        idle();
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 32'(pred_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_redir", 32'(redirect_valid), 32'd0);
        chk("rst_redir_pc", redirect_pc, 32'd0);
        chk("rst_train", 32'(train_valid), 32'd0);
        chk("rst_uflow", 32'(underflow_err), 32'd0);
        chk("rst_bcnt", branch_cnt, 32'd0);
        chk("rst_mcnt", mispred_cnt, 32'd0);

        // 1: correct taken branch
        push(1'b0, 1'b1, 32'h100, 32'h140);
        chk("t1_count_push", 32'(count), 32'd1);
        resolve(1'b1, 32'h140);
        chk("t1_redir", 32'(redirect_valid), 32'd0);
        chk("t1_train_v", 32'(train_valid), 32'd1);
        chk("t1_train_t", 32'(train_taken), 32'd1);
        chk("t1_bcnt", branch_cnt, 32'd1);
        chk("t1_count", 32'(count), 32'd0);

        // 2: predicted taken, actually not taken
        push(1'b0, 1'b1, 32'h200, 32'h240);
        resolve(1'b0, 32'h0);
        chk("t2_redir", 32'(redirect_valid), 32'd1);
        chk("t2_redir_pc", redirect_pc, 32'h204);
        chk("t2_mcnt", mispred_cnt, 32'd1);
        chk("t2_count", 32'(count), 32'd0);
        chk("t2_train_t", 32'(train_taken), 32'd0);
        step();
        chk("t2_pulse_end", 32'(redirect_valid), 32'd0);
        chk("t2_train_end", 32'(train_valid), 32'd0);

        // 3: predicted not-taken, actually taken; same-cycle push is wrong-path
        push(1'b0, 1'b0, 32'h300, 32'h380);
        set_pred(1'b0, 1'b1, 32'h400, 32'h440);
        set_res(1'b1, 32'h380);
        step();
        idle();
        chk("t3_redir", 32'(redirect_valid), 32'd1);
        chk("t3_redir_pc", redirect_pc, 32'h380);
        chk("t3_count", 32'(count), 32'd0);
        chk("t3_mcnt", mispred_cnt, 32'd2);
        chk("t3_bcnt", branch_cnt, 32'd3);

        // 4: fill, drop when full, push+pop keeps count, order preserved
        for (int i = 0; i < 4; i++)
            push(1'b0, 1'b1, 32'h500 + 32'(4 * i), 32'h540 + 32'(4 * i));
        chk("t4_full_count", 32'(count), 32'd4);
        chk("t4_ready", 32'(pred_ready), 32'd0);
        push(1'b0, 1'b1, 32'h510, 32'h550);
        chk("t4_drop_count", 32'(count), 32'd4);
        resolve(1'b1, 32'h540);
        chk("t4_pop_redir", 32'(redirect_valid), 32'd0);
        chk("t4_pop_count", 32'(count), 32'd3);
        set_pred(1'b0, 1'b1, 32'h600, 32'h640);
        set_res(1'b1, 32'h544);
        step();
        idle();
        chk("t4_pp_count", 32'(count), 32'd3);
        chk("t4_pp_redir", 32'(redirect_valid), 32'd0);
        resolve(1'b0, 32'h0);
        chk("t4_order_redir", 32'(redirect_valid), 32'd1);
        chk("t4_order_pc", redirect_pc, 32'h50c);
        chk("t4_clear_count", 32'(count), 32'd0);
        chk("t4_bcnt", branch_cnt, 32'd6);
        chk("t4_mcnt", mispred_cnt, 32'd3);

        // 5: JAL with matching target: no training, no redirect
        push(1'b1, 1'b1, 32'h700, 32'h7f0);
        resolve(1'b1, 32'h7f0);
        chk("t5_train_v", 32'(train_valid), 32'd0);
        chk("t5_redir", 32'(redirect_valid), 32'd0);
        chk("t5_bcnt", branch_cnt, 32'd6);
        chk("t5_mcnt", mispred_cnt, 32'd3);

        // 6: underflow and external flush
        resolve(1'b1, 32'h123);
        chk("t6_uflow", 32'(underflow_err), 32'd1);
        chk("t6_uf_redir", 32'(redirect_valid), 32'd0);
        chk("t6_uf_train", 32'(train_valid), 32'd0);
        step();
        step();
        chk("t6_uflow_sticky", 32'(underflow_err), 32'd1);
        for (int i = 0; i < 3; i++)
            push(1'b0, 1'b0, 32'h800 + 32'(4 * i), 32'h0);
        chk("t6_count3", 32'(count), 32'd3);
        flush_in = 1'b1;
        set_pred(1'b0, 1'b0, 32'h900, 32'h0);
        step();
        idle();
        chk("t6_flush_count", 32'(count), 32'd0);
        chk("t6_flush_redir", 32'(redirect_valid), 32'd0);

        // Flush coinciding with a mispredicting resolve still redirects
        push(1'b0, 1'b1, 32'ha00, 32'ha40);
        flush_in = 1'b1;
        set_res(1'b0, 32'h0);
        step();
        idle();
        chk("t7_redir", 32'(redirect_valid), 32'd1);
        chk("t7_redir_pc", redirect_pc, 32'ha04);
        chk("t7_count", 32'(count), 32'd0);
        chk("t7_mcnt", mispred_cnt, 32'd4);

        // Reset mid-operation suppresses the pending pulse
        push(1'b0, 1'b1, 32'hb00, 32'hb40);
        set_res(1'b0, 32'h0);
        rst = 1'b1;
        step();
        idle();
        rst = 1'b0;
        chk("t8_redir", 32'(redirect_valid), 32'd0);
        chk("t8_train", 32'(train_valid), 32'd0);
        chk("t8_count", 32'(count), 32'd0);
        chk("t8_uflow", 32'(underflow_err), 32'd0);
        chk("t8_mcnt", mispred_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
